checking_consumer: RTL and testbench
====================================

Name: checking_consumer

Overview:
Self-checking sink that sits directly downstream of the arf "out" port (dout_req/dout_ack/dout) in the simulation benches. It drives the same req/ack pull handshake as the plain bench consumer and counts accepted words. It also compares each word against an affine golden sequence, scale*n + offset, which matches arf graphs of the form 3*x + 2. It reports error count, first-mismatch capture, done and pass, so benches can assert functional correctness as well as throughput.

Parameters:
consumer_id, 0, tag printed in $write trace lines
data_width, 32, data bus width
scale, 3, golden multiplier per sample index
offset, 2, golden additive constant
initial_value, 0, producer start value; golden n starts here
max_data_size, 5000, words to accept before done
stall_period, 0, 0 = never stall; N>1 = req forced low one cycle in every N (deterministic back-pressure)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  out  1  registered request to upstream ack_r source
ack  in  1  upstream data-valid pulse
din  in  data_width  upstream data, valid when ack=1
count  out  32  words accepted
err_count  out  32  mismatching words
first_err_idx  out  32  count value at first mismatch; 0xFFFFFFFF if none
first_err_data  out  data_width  din at first mismatch
first_err_exp  out  data_width  golden value at first mismatch
overrun  out  1  sticky; ack seen while in DONE or with req_q=0
done  out  1  high once count == max_data_size
pass  out  1  done & err_count==0 & ~overrun

Behaviour:
- Reset: req=0, count=0, err_count=0, first_err_idx=all ones, first_err_data=0, first_err_exp=0, overrun=0, done=0, pass=0. exp_r=scale*initial_value+offset (data_width truncation), stall counter=0, state=RUN. Reset mid-run discards all state; the next non-reset cycle restarts from the same values.
- States:
  - RUN: req<=~stall_now every cycle.
  - DONE: req<=0 permanently. Only rst leaves DONE.
- stall_now is 1 when stall_period>1 and the stall counter equals stall_period-1. The counter wraps to 0 after that value and advances every RUN cycle.
- req_q is req delayed one cycle. A valid accept is ack=1 in RUN with req_q=1. ack=1 in DONE, or with req_q=0, sets overrun and is otherwise ignored.
- Accept, same edge:
  - count+=1 and exp_r+=scale, both modulo their widths; no multiplier in the datapath.
  - If din!=exp_r: err_count+=1 (saturating at all ones).
  - On the first mismatch only (first_err_idx==all ones): capture count (pre-increment), din and exp_r.
  - $write trace line with consumer_id and din.
- Completion: when an accept makes count==max_data_size, go to DONE with done=1 and req=0 on the same edge. pass is combinational from registered terms.
- Latency: error flags update on the edge that samples ack, i.e. visible the cycle after the ack pulse.
- Back-to-back ack on consecutive cycles is legal; each one is an accept if its req_q=1.
- max_data_size=0: enter DONE on the first cycle after reset.
- Golden arithmetic wraps at data_width. Example: width 8, n=85 gives 257 -> 1.

Decomposition:
- Shared bench package: handshake-role localparams, the NONE_IDX=32'hFFFFFFFF constant, and a function golden(n,scale,offset,width) for the bench's scoreboard.
- One sub-module is natural: stall_gen (period counter producing stall_now). It is reusable by the producer-side bench blocks.

Test Plan:
- No stall, ack pulses with din 2,5,8,11 (req_q=1) -> count=4, err_count=0, first_err_idx=FFFFFFFF.
- din sequence 2,5,9,11 -> err_count=1, first_err_idx=2, first_err_data=9, first_err_exp=8; after max_data_size=4, done=1, pass=0.
- stall_period=4, free-running ack-on-req source -> req low exactly every 4th cycle; count reaches max_data_size=8 with err_count=0, pass=1.
- ack pulse one cycle after done -> overrun=1, count unchanged, pass=0.
- data_width=8, initial_value=85 -> first expected 1; din=1 accepted without error.
- Reset after 3 accepts -> all outputs at reset values next cycle; a fresh sequence 2,5 accepted with err_count=0.

Source files
------------

// File: rtl/checking_consumer_pkg.sv
// checking_consumer_pkg: shared types, constants and golden-sequence helper for the checking consumer bench blocks
package checking_consumer_pkg;
  typedef enum logic {RUN, DONE} state_t;
  localparam int ROLE_PRODUCER = 0;
  localparam int ROLE_CONSUMER = 1;
  localparam logic [31:0] NONE_IDX = 32'hFFFF_FFFF;
  function automatic logic [63:0] golden(input longint n, input longint s, input longint o, input int width);
    logic [63:0] v;
    v = 64'(s * n + o);
    return width >= 64 ? v : v & ((64'd1 << width) - 64'd1);
  endfunction
endpackage

// File: rtl/checking_consumer_stall_gen.sv
// stall_gen: period counter that flags one stall cycle in every period enabled cycles
module stall_gen #(
  parameter int period = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic stall_now
);
  localparam int CW = period > 2 ? $clog2(period) : 1;
  logic [CW-1:0] cnt;
  assign stall_now = period > 1 && cnt == CW'(period - 1);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= (stall_now || period <= 1) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/checking_consumer.sv
// checking_consumer: req/ack pull sink that counts words and checks them against scale*n + offset
module checking_consumer
  import checking_consumer_pkg::*;
#(
  parameter int consumer_id   = 0,
  parameter int data_width    = 32,
  parameter int scale         = 3,
  parameter int offset        = 2,
  parameter int initial_value = 0,
  parameter int max_data_size = 5000,
  parameter int stall_period  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req,
  input  logic                  ack,
  input  logic [data_width-1:0] din,
  output logic [31:0]           count,
  output logic [31:0]           err_count,
  output logic [31:0]           first_err_idx,
  output logic [data_width-1:0] first_err_data,
  output logic [data_width-1:0] first_err_exp,
  output logic                  overrun,
  output logic                  done,
  output logic                  pass
);
  localparam logic [data_width-1:0] EXP0 =
    data_width'(golden(longint'(initial_value), longint'(scale), longint'(offset), data_width));
  state_t state;
  logic req_q, stall_now, accept, hit_max;
  logic [data_width-1:0] exp_r;
  stall_gen #(.period(stall_period)) u_stall (
    .clk(clk),
    .rst(rst),
    .en(state == RUN),
    .stall_now(stall_now)
  );
  assign accept  = ack && state == RUN && req_q;
  assign hit_max = max_data_size == 0 || (accept && count + 32'd1 == 32'(max_data_size));
  assign pass    = done && err_count == '0 && !overrun;
  // golden value advances by addition so the datapath needs no multiplier
  always_ff @(posedge clk)
    if (rst) begin
      state          <= RUN;
      req            <= 1'b0;
      req_q          <= 1'b0;
      count          <= '0;
      err_count      <= '0;
      first_err_idx  <= NONE_IDX;
      first_err_data <= '0;
      first_err_exp  <= '0;
      overrun        <= 1'b0;
      done           <= 1'b0;
      exp_r          <= EXP0;
    end else begin
      req_q <= req;
      if (ack && !accept) overrun <= 1'b1;
      if (accept) begin
        count <= count + 32'd1;
        exp_r <= exp_r + data_width'(scale);
        if (din != exp_r) begin
          if (err_count != '1) err_count <= err_count + 32'd1;
          if (first_err_idx == NONE_IDX) begin
            first_err_idx  <= count;
            first_err_data <= din;
            first_err_exp  <= exp_r;
          end
        end
        $write("consumer %0d accept %0h\n", consumer_id, din);
      end
      if (state == RUN && hit_max) begin
        state <= DONE;
        done  <= 1'b1;
        req   <= 1'b0;
      end else req <= state == RUN && !stall_now;
    end
endmodule

// File: tb/tb_checking_consumer.sv
// tb_checking_consumer: scenario tasks against a golden-sequence model over four differently configured consumers
module tb_checking_consumer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;

  logic rst_a = 1'b1, ack_a = 1'b0, req_a, ovr_a, done_a, pass_a;
  logic [31:0] din_a = '0, count_a, err_a, fidx_a, fdata_a, fexp_a;
  logic rst_s = 1'b1, ack_s = 1'b0, req_s, ovr_s, done_s, pass_s;
  logic [31:0] din_s = '0, count_s, err_s, fidx_s, fdata_s, fexp_s;
  logic rst_w = 1'b1, ack_w = 1'b0, req_w, ovr_w, done_w, pass_w;
  logic [7:0] din_w = '0, fdata_w, fexp_w;
  logic [31:0] count_w, err_w, fidx_w;
  logic rst_z = 1'b1, ack_z = 1'b0, req_z, ovr_z, done_z, pass_z;
  logic [31:0] din_z = '0, count_z, err_z, fidx_z, fdata_z, fexp_z;
  logic pr_a, pr_s, pr_w;

  checking_consumer #(.consumer_id(0), .max_data_size(4)) u_a (
    .clk(clk), .rst(rst_a), .req(req_a), .ack(ack_a), .din(din_a), .count(count_a),
    .err_count(err_a), .first_err_idx(fidx_a), .first_err_data(fdata_a), .first_err_exp(fexp_a),
    .overrun(ovr_a), .done(done_a), .pass(pass_a));
  checking_consumer #(.consumer_id(1), .max_data_size(8), .stall_period(4)) u_s (
    .clk(clk), .rst(rst_s), .req(req_s), .ack(ack_s), .din(din_s), .count(count_s),
    .err_count(err_s), .first_err_idx(fidx_s), .first_err_data(fdata_s), .first_err_exp(fexp_s),
    .overrun(ovr_s), .done(done_s), .pass(pass_s));
  checking_consumer #(.consumer_id(2), .data_width(8), .initial_value(85), .max_data_size(4)) u_w (
    .clk(clk), .rst(rst_w), .req(req_w), .ack(ack_w), .din(din_w), .count(count_w),
    .err_count(err_w), .first_err_idx(fidx_w), .first_err_data(fdata_w), .first_err_exp(fexp_w),
    .overrun(ovr_w), .done(done_w), .pass(pass_w));
  checking_consumer #(.consumer_id(3), .max_data_size(0)) u_z (
    .clk(clk), .rst(rst_z), .req(req_z), .ack(ack_z), .din(din_z), .count(count_z),
    .err_count(err_z), .first_err_idx(fidx_z), .first_err_data(fdata_z), .first_err_exp(fexp_z),
    .overrun(ovr_z), .done(done_z), .pass(pass_z));

  int unsigned m_n, m_err;
  logic [31:0] m_fidx, m_fdata, m_fexp;
  bit m_ovr;

  function automatic logic [31:0] gold_a(input int unsigned n);
    return 32'(3 * n + 2);
  endfunction
  function automatic logic [7:0] gold_w(input int unsigned n);
    return 8'(3 * (85 + n) + 2);
  endfunction

  // remembers each consumer's req in the cycle being closed, i.e. the req_q the edge will see
  task automatic step();
    pr_a = req_a; pr_s = req_s; pr_w = req_w;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    ack_a = 1'b0; rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    m_n = 0; m_err = 0; m_fidx = 32'hFFFF_FFFF; m_fdata = '0; m_fexp = '0; m_ovr = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] d);
    int k = 0;
    step();
    while (!pr_a && k < 20) begin ack_a = 1'b0; step(); k++; end
    if (!pr_a) begin
      n_chk++;
      $display("FAIL send_a_timeout: req=%b after %0d cycles, required 1", pr_a, k);
      ack_a = 1'b0;
      return;
    end
    ack_a = 1'b1; din_a = d;
    if (d !== gold_a(m_n)) begin
      if (m_fidx == 32'hFFFF_FFFF) begin m_fidx = m_n; m_fdata = d; m_fexp = gold_a(m_n); end
      m_err++;
    end
    m_n++;
  endtask

  task automatic idle_a();
    step();
    ack_a = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] d);
    int k = 0;
    step();
    while (!pr_w && k < 20) begin ack_w = 1'b0; step(); k++; end
    if (!pr_w) begin
      n_chk++;
      $display("FAIL send_w_timeout: req=%b after %0d cycles, required 1", pr_w, k);
      ack_w = 1'b0;
      return;
    end
    ack_w = 1'b1; din_w = d;
  endtask

  task automatic test_reset();
    step();
    reset_a();
    n_chk++; if (req_a !== 1'b0) $display("FAIL reset_req: got %b want 0", req_a); else n_pass++;
    n_chk++; if (count_a !== 32'd0) $display("FAIL reset_count: got %0d want 0", count_a); else n_pass++;
    n_chk++; if (err_a !== 32'd0) $display("FAIL reset_err: got %0d want 0", err_a); else n_pass++;
    n_chk++; if (fidx_a !== 32'hFFFF_FFFF) $display("FAIL reset_fidx: got %h want ffffffff", fidx_a); else n_pass++;
    n_chk++; if (fdata_a !== 32'd0) $display("FAIL reset_fdata: got %h want 0", fdata_a); else n_pass++;
    n_chk++; if (fexp_a !== 32'd0) $display("FAIL reset_fexp: got %h want 0", fexp_a); else n_pass++;
    n_chk++; if ({ovr_a, done_a, pass_a} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {ovr_a, done_a, pass_a}); else n_pass++;
  endtask

  task automatic test_clean();
    reset_a();
    send_a(32'd2); send_a(32'd5); send_a(32'd8); send_a(32'd11);
    idle_a();
    n_chk++; if (count_a !== 32'd4) $display("FAIL clean_count: got %0d want 4", count_a); else n_pass++;
    n_chk++; if (err_a !== 32'd0) $display("FAIL clean_err: got %0d want 0", err_a); else n_pass++;
    n_chk++; if (fidx_a !== 32'hFFFF_FFFF) $display("FAIL clean_fidx: got %h want ffffffff", fidx_a); else n_pass++;
    n_chk++; if ({done_a, pass_a, req_a} !== 3'b110) $display("FAIL clean_done_pass_req: got %b want 110", {done_a, pass_a, req_a}); else n_pass++;
  endtask

  task automatic test_overrun();
    ack_a = 1'b1; din_a = 32'd14;
    step();
    ack_a = 1'b0;
    step();
    n_chk++; if (ovr_a !== 1'b1) $display("FAIL overrun_flag: got %b want 1", ovr_a); else n_pass++;
    n_chk++; if (count_a !== 32'd4) $display("FAIL overrun_count: got %0d want 4", count_a); else n_pass++;
    n_chk++; if (pass_a !== 1'b0) $display("FAIL overrun_pass: got %b want 0", pass_a); else n_pass++;
  endtask

  task automatic test_mismatch();
    reset_a();
    send_a(32'd2); send_a(32'd5); send_a(32'd9); send_a(32'd11);
    idle_a();
    n_chk++; if (err_a !== 32'd1) $display("FAIL mm_err: got %0d want 1", err_a); else n_pass++;
    n_chk++; if (fidx_a !== 32'd2) $display("FAIL mm_fidx: got %0d want 2", fidx_a); else n_pass++;
    n_chk++; if (fdata_a !== 32'd9) $display("FAIL mm_fdata: got %0d want 9", fdata_a); else n_pass++;
    n_chk++; if (fexp_a !== 32'd8) $display("FAIL mm_fexp: got %0d want 8", fexp_a); else n_pass++;
    n_chk++; if ({done_a, pass_a} !== 2'b10) $display("FAIL mm_done_pass: got %b want 10", {done_a, pass_a}); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    reset_a();
    send_a(32'd2); send_a(32'd7); send_a(32'd8);
    idle_a();
    reset_a();
    n_chk++; if ({count_a, err_a} !== 64'd0) $display("FAIL midrst_counts: got %0d/%0d want 0/0", count_a, err_a); else n_pass++;
    n_chk++; if (fidx_a !== 32'hFFFF_FFFF) $display("FAIL midrst_fidx: got %h want ffffffff", fidx_a); else n_pass++;
    n_chk++; if ({fdata_a, fexp_a} !== 64'd0) $display("FAIL midrst_capture: got %h/%h want 0/0", fdata_a, fexp_a); else n_pass++;
    n_chk++; if ({req_a, ovr_a, done_a, pass_a} !== 4'b0000) $display("FAIL midrst_flags: got %b want 0000", {req_a, ovr_a, done_a, pass_a}); else n_pass++;
    send_a(32'd2); send_a(32'd5);
    idle_a();
    n_chk++; if (count_a !== 32'd2) $display("FAIL midrst_recount: got %0d want 2", count_a); else n_pass++;
    n_chk++; if (err_a !== 32'd0) $display("FAIL midrst_reerr: got %0d want 0", err_a); else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int unsigned nw;
      reset_a();
      if ($urandom_range(0, 3) == 0) begin ack_a = 1'b1; din_a = $urandom; m_ovr = 1'b1; end
      nw = $urandom_range(1, 4);
      for (int i = 0; i < int'(nw); i++) begin
        send_a(($urandom_range(0, 2) == 0) ? 32'($urandom) : gold_a(m_n));
        if ($urandom_range(0, 2) == 0) begin step(); ack_a = 1'b0; end
      end
      idle_a();
      if (m_n == 4 && $urandom_range(0, 1) == 1) begin ack_a = 1'b1; step(); ack_a = 1'b0; m_ovr = 1'b1; end
      n_chk++; if (count_a !== m_n) $display("FAIL rnd%0d_count: got %0d want %0d", r, count_a, m_n); else n_pass++;
      n_chk++; if (err_a !== m_err) $display("FAIL rnd%0d_err: got %0d want %0d", r, err_a, m_err); else n_pass++;
      n_chk++; if (fidx_a !== m_fidx) $display("FAIL rnd%0d_fidx: got %h want %h", r, fidx_a, m_fidx); else n_pass++;
      n_chk++; if ({fdata_a, fexp_a} !== {m_fdata, m_fexp}) $display("FAIL rnd%0d_capture: got %h/%h want %h/%h", r, fdata_a, fexp_a, m_fdata, m_fexp); else n_pass++;
      n_chk++; if (ovr_a !== m_ovr) $display("FAIL rnd%0d_overrun: got %b want %b", r, ovr_a, m_ovr); else n_pass++;
      n_chk++; if (done_a !== (m_n == 4)) $display("FAIL rnd%0d_done: got %b want %b", r, done_a, m_n == 4); else n_pass++;
      n_chk++; if (pass_a !== (m_n == 4 && m_err == 0 && !m_ovr)) $display("FAIL rnd%0d_pass: got %b want %b", r, pass_a, m_n == 4 && m_err == 0 && !m_ovr); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int last = -1, lows = 0, bad = 0;
    int unsigned m = 0;
    logic prev = 1'b0;
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    for (int cyc = 0; cyc < 100 && !done_s; cyc++) begin
      if (!req_s && cyc > 0) begin
        if ((last < 0 && cyc != 4) || (last >= 0 && cyc - last != 4)) bad++;
        last = cyc; lows++;
      end
      ack_s = prev; din_s = gold_a(m);
      if (ack_s) m++;
      prev = req_s;
      step();
    end
    ack_s = 1'b0;
    n_chk++; if (done_s !== 1'b1) $display("FAIL stall_done: got %b want 1 within 100 cycles", done_s); else n_pass++;
    step();
    n_chk++; if (bad !== 0) $display("FAIL stall_spacing: got %0d irregular req-low cycles want 0", bad); else n_pass++;
    n_chk++; if (lows !== 2) $display("FAIL stall_lows: got %0d req-low cycles want 2", lows); else n_pass++;
    n_chk++; if (count_s !== 32'd8) $display("FAIL stall_count: got %0d want 8", count_s); else n_pass++;
    n_chk++; if (err_s !== 32'd0) $display("FAIL stall_err: got %0d want 0", err_s); else n_pass++;
    n_chk++; if ({ovr_s, pass_s, req_s} !== 3'b010) $display("FAIL stall_flags: got %b want 010", {ovr_s, pass_s, req_s}); else n_pass++;
  endtask

  task automatic test_wrap();
    rst_w = 1'b1;
    step();
    rst_w = 1'b0;
    send_w(gold_w(0));
    step(); ack_w = 1'b0;
    n_chk++; if (count_w !== 32'd1) $display("FAIL wrap_count1: got %0d want 1", count_w); else n_pass++;
    n_chk++; if (err_w !== 32'd0) $display("FAIL wrap_err1: got %0d want 0 (din %0d)", err_w, din_w); else n_pass++;
    send_w(gold_w(1));
    send_w(gold_w(2) ^ 8'h07);
    step(); ack_w = 1'b0;
    n_chk++; if (err_w !== 32'd1) $display("FAIL wrap_err: got %0d want 1", err_w); else n_pass++;
    n_chk++; if (fidx_w !== 32'd2) $display("FAIL wrap_fidx: got %0d want 2", fidx_w); else n_pass++;
    n_chk++; if (fexp_w !== 8'd7) $display("FAIL wrap_fexp: got %0d want 7", fexp_w); else n_pass++;
    n_chk++; if (fdata_w !== 8'd0) $display("FAIL wrap_fdata: got %0d want 0", fdata_w); else n_pass++;
  endtask

  task automatic test_zero_size();
    rst_z = 1'b1;
    step();
    rst_z = 1'b0;
    n_chk++; if (done_z !== 1'b0) $display("FAIL zero_done_at_reset: got %b want 0", done_z); else n_pass++;
    step();
    n_chk++; if ({done_z, req_z, pass_z} !== 3'b101) $display("FAIL zero_done_req_pass: got %b want 101", {done_z, req_z, pass_z}); else n_pass++;
    n_chk++; if (count_z !== 32'd0) $display("FAIL zero_count: got %0d want 0", count_z); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_overrun();
    test_mismatch();
    test_reset_midrun();
    test_random();
    test_stall();
    test_wrap();
    test_zero_size();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
